// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner type and the counter-width helper for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {OWN_CORE, OWN_DBG} owner_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: W-bit counter, clr has priority over inc, holds at MAX (ports: clk, rst active-low async, clr, inc, cnt)
module sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: parks dmem on the core, grants bounded debug bursts with starvation protection (ports: core_*, dbg_*, mem_*, clk, rst active-low async)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [DWIDTH-1:0] core_wdata,
  output logic [DWIDTH-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_addr,
  input  logic [DWIDTH-1:0] dbg_wdata,
  input  logic              dbg_last,
  output logic              dbg_gnt,
  output logic [DWIDTH-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);
  localparam int BW = cnt_w(MAX_BURST);
  localparam int SW = cnt_w(STARVE_LIMIT);
  owner_t owner, owner_nxt;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] wait_cnt;
  logic is_dbg, beat, wait_done, burst_done, wait_inc, beat_inc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) owner <= OWN_CORE;
    else owner <= owner_nxt;
  always_comb begin
    is_dbg     = owner == OWN_DBG;
    beat       = is_dbg & dbg_req;
    wait_done  = wait_cnt == SW'(STARVE_LIMIT - 1);
    burst_done = beat_cnt == BW'(MAX_BURST - 1);
    owner_nxt  = is_dbg ? ((!dbg_req || dbg_last || burst_done) ? OWN_CORE : OWN_DBG)
                        : ((dbg_req && (!core_req || wait_done)) ? OWN_DBG : OWN_CORE);
    // wait_cnt only advances while the core is actually blocking a debug request
    wait_inc   = !is_dbg & dbg_req & core_req & !wait_done;
    beat_inc   = beat & (owner_nxt == OWN_DBG);
  end
  sat_counter #(.W(SW), .MAX(STARVE_LIMIT - 1)) u_wait (
    .clk(clk), .rst(rst), .clr(!wait_inc), .inc(wait_inc), .cnt(wait_cnt)
  );
  sat_counter #(.W(BW), .MAX(MAX_BURST - 1)) u_beat (
    .clk(clk), .rst(rst), .clr(owner_nxt == OWN_CORE), .inc(beat_inc), .cnt(beat_cnt)
  );
  assign mem_addr   = is_dbg ? dbg_addr : core_addr;
  assign mem_wdata  = is_dbg ? dbg_wdata : core_wdata;
  assign mem_we     = is_dbg ? (dbg_req & dbg_we) : (core_req & core_we);
  assign core_rdata = mem_rdata;
  assign core_stall = is_dbg & core_req;
  assign dbg_gnt    = is_dbg;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= beat & !dbg_we;
      if (beat && !dbg_we) dbg_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a cycle-level behavioural model
module tb_dmem_arbiter;
  localparam int MB = 8;
  localparam int SL = 4;
  logic clk = 0, rst = 0;
  logic core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0, dbg_last = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic core_stall, dbg_gnt, dbg_rvalid, mem_we;
  logic [31:0] mem [0:255];
  logic [31:0] mm [0:255];
  bit m_dbg, m_rv, got_gnt;
  int m_wait, m_beats;
  logic [31:0] m_rd;
  int checks = 0, passes = 0;

  dmem_arbiter #(.DWIDTH(32), .AWIDTH(32), .MAX_BURST(MB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_last(dbg_last), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic model_reset();
    m_dbg = 0; m_rv = 0; m_rd = 0; m_wait = 0; m_beats = 0;
  endtask

  // One clock: check combinational outputs against the model, advance the model, cross the edge.
  task automatic step();
    logic ewe;
    logic [31:0] ea, ewd;
    bit od;
    #3;
    ewe = m_dbg ? (dbg_req & dbg_we) : (core_req & core_we);
    ea  = m_dbg ? dbg_addr : core_addr;
    ewd = m_dbg ? dbg_wdata : core_wdata;
    checks++; if (dbg_gnt !== m_dbg) $display("FAIL gnt: got %0b exp %0b t=%0t", dbg_gnt, m_dbg, $time); else passes++;
    checks++; if (core_stall !== (m_dbg & core_req)) $display("FAIL stall: got %0b exp %0b t=%0t", core_stall, m_dbg & core_req, $time); else passes++;
    checks++; if (mem_we !== ewe) $display("FAIL mem_we: got %0b exp %0b t=%0t", mem_we, ewe, $time); else passes++;
    checks++; if (mem_addr !== ea) $display("FAIL mem_addr: got %h exp %h t=%0t", mem_addr, ea, $time); else passes++;
    if (ewe) begin
      checks++; if (mem_wdata !== ewd) $display("FAIL mem_wdata: got %h exp %h t=%0t", mem_wdata, ewd, $time); else passes++;
    end
    if (!m_dbg && core_req && !core_we) begin
      checks++; if (core_rdata !== mm[core_addr[7:0]]) $display("FAIL core_rdata: got %h exp %h t=%0t", core_rdata, mm[core_addr[7:0]], $time); else passes++;
    end
    checks++; if (dbg_rvalid !== m_rv) $display("FAIL rvalid: got %0b exp %0b t=%0t", dbg_rvalid, m_rv, $time); else passes++;
    if (m_rv) begin
      checks++; if (dbg_rdata !== m_rd) $display("FAIL dbg_rdata: got %h exp %h t=%0t", dbg_rdata, m_rd, $time); else passes++;
    end
    got_gnt = dbg_gnt;
    od = m_dbg;
    if (!od) begin
      m_beats = 0;
      if (dbg_req && !core_req) begin m_dbg = 1; m_wait = 0; end
      else if (dbg_req && core_req) begin
        if (m_wait == SL - 1) begin m_dbg = 1; m_wait = 0; end
        else m_wait++;
      end else m_wait = 0;
    end else begin
      if (!dbg_req || dbg_last || m_beats == MB - 1) begin m_dbg = 0; m_beats = 0; end
      else m_beats++;
    end
    if (od && dbg_req && !dbg_we) begin m_rv = 1; m_rd = mm[dbg_addr[7:0]]; end
    else m_rv = 0;
    if (ewe) mm[ea[7:0]] = ewd;
    @(posedge clk); #1;
  endtask

  // Presents n debug beats, advancing only on granted cycles; reports first-grant cycle and grant gaps.
  task automatic dbg_burst(input int n, input bit we, input logic [31:0] base, output int first, output int gaps);
    int i = 0, cyc = 0;
    first = -1; gaps = 0;
    while (i < n && cyc < 200) begin
      dbg_req = 1; dbg_we = we; dbg_addr = base + i; dbg_wdata = $urandom; dbg_last = (i == n - 1);
      step(); cyc++;
      if (got_gnt) begin if (first < 0) first = cyc; i++; end
      else if (first >= 0) gaps++;
    end
    if (i < n) begin checks++; $display("FAIL burst_timeout: got %0d beats exp %0d", i, n); end
    dbg_req = 0; dbg_last = 0; dbg_we = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk); #1;
    model_reset();
    checks++; if (dbg_gnt !== 0 || dbg_rvalid !== 0 || dbg_rdata !== 0) $display("FAIL reset_state: gnt=%0b rvalid=%0b rdata=%h exp 0/0/0", dbg_gnt, dbg_rvalid, dbg_rdata); else passes++;
    rst = 1;
  endtask

  task automatic test_reset();
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hA5; dbg_req = 0;
    do_reset();
    step();
    checks++; if (mem[8'h10] !== 32'hA5) $display("FAIL core_store: got %h exp %h", mem[8'h10], 32'hA5); else passes++;
    core_req = 0; core_we = 0;
  endtask

  task automatic test_dbg_write();
    int first, gaps;
    dbg_burst(3, 1, 32'h40, first, gaps);
    checks++; if (first !== 2) $display("FAIL dbg3_first: got %0d exp 2", first); else passes++;
    checks++; if (gaps !== 0) $display("FAIL dbg3_gaps: got %0d exp 0", gaps); else passes++;
    step();
  endtask

  task automatic test_starvation();
    int first, gaps;
    core_req = 1; core_we = 0; core_addr = 32'h10;
    dbg_burst(2, 1, 32'h50, first, gaps);
    checks++; if (first !== SL + 1) $display("FAIL starve_first: got %0d exp %0d", first, SL + 1); else passes++;
    step();
    core_req = 0;
    step();
  endtask

  task automatic test_max_burst();
    int first, gaps;
    dbg_burst(12, 1, 32'h80, first, gaps);
    checks++; if (first !== 2) $display("FAIL burst12_first: got %0d exp 2", first); else passes++;
    checks++; if (gaps !== 1) $display("FAIL burst12_gaps: got %0d exp 1", gaps); else passes++;
    step();
  endtask

  task automatic test_read();
    int first, gaps;
    mem[8'h20] = 32'hDEADBEEF; mm[8'h20] = 32'hDEADBEEF;
    dbg_burst(1, 0, 32'h20, first, gaps);
    #3;
    checks++; if (dbg_rvalid !== 1'b1) $display("FAIL read_rvalid: got %0b exp 1", dbg_rvalid); else passes++;
    checks++; if (dbg_rdata !== 32'hDEADBEEF) $display("FAIL read_data: got %h exp deadbeef", dbg_rdata); else passes++;
    @(posedge clk); #1;
    m_rv = 0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h90; dbg_wdata = 32'h1234; dbg_last = 0;
    step(); step();
    core_req = 1; core_we = 0; core_addr = 32'h90;
    #2 rst = 0;
    #1;
    checks++; if (dbg_gnt !== 0 || dbg_rvalid !== 0) $display("FAIL async_reset: gnt=%0b rvalid=%0b exp 0/0", dbg_gnt, dbg_rvalid); else passes++;
    checks++; if (core_stall !== 0 || mem_we !== 0) $display("FAIL reset_core: stall=%0b mem_we=%0b exp 0/0", core_stall, mem_we); else passes++;
    dbg_req = 0; dbg_we = 0;
    @(posedge clk); #1;
    model_reset();
    rst = 1;
    step(); step();
    core_req = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      core_req = ($urandom_range(0, 1) == 1); core_we = $urandom_range(0, 1);
      core_addr = $urandom_range(0, 255); core_wdata = $urandom;
      dbg_req = ($urandom_range(0, 9) < 6); dbg_we = $urandom_range(0, 1);
      dbg_addr = $urandom_range(0, 255); dbg_wdata = $urandom;
      dbg_last = ($urandom_range(0, 3) == 0);
      step();
    end
    core_req = 0; dbg_req = 0; dbg_last = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 0; mm[i] = 0; end
    model_reset();
    #1;
    test_reset();
    test_dbg_write();
    test_starvation();
    test_max_burst();
    test_read();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
